// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//
// Purpose:
//   Instruction-memory responder for a fetch unit. It holds a word-addressed
//   program array that a loader fills through a write strobe. It serves one
//   fetch at a time and returns the word a fixed number of cycles after the
//   request is accepted. The response is held until the fetch side takes it.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit instruction words (power of two, >= 2)
//   LATENCY      cycles from request acceptance to rsp_valid_o (1..7)
//
// Ports:
//   clk          sole clock, all state updates on the rising edge
//   rst          synchronous active-high reset (memory contents are kept)
//   req_valid_i  fetch request present
//   req_ready_o  request accepted this cycle when req_valid_i is also high
//   req_addr_i   byte address of the fetch (PC)
//   rsp_valid_o  response word available
//   rsp_ready_i  fetch side consumes the response
//   rsp_inst_o   fetched instruction (0 while rsp_valid_o is low)
//   rsp_err_o    fault on the current response (0 while rsp_valid_o is low)
//   load_en_i    program-load write strobe
//   load_addr_i  byte address of the load write
//   load_data_i  load write data
//   busy_o       high whenever a request is outstanding
//
// Configuration:
//   IMEM_ALIGN_CHECK_EN  when defined, a fetch with a non-word-aligned address
//                        returns an error response, and a misaligned load write
//                        is dropped. When undefined, address bits [1:0] are
//                        ignored.
// -----------------------------------------------------------------------------
module imem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_inst_o,
    output logic        rsp_err_o,
    input  logic        load_en_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i,
    output logic        busy_o
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    // The bound is 33 bits wide so that a 2^30-word array does not overflow.
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    // WAIT lasts LATENCY-1 cycles. The counter starts at LATENCY-2 and the
    // FSM leaves WAIT when the counter reads zero.
    localparam logic [2:0]  WAIT_INIT  = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [2:0]    cnt;
    logic [31:0]   inst_q;
    logic          err_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] fetch_idx;
    logic [AW-1:0] load_idx;
    logic          fetch_in_range;
    logic          load_in_range;
    logic          fetch_misaligned;
    logic          load_misaligned;
    logic          fetch_err;
    logic          load_ok;
    logic          accept;

    assign fetch_idx      = req_addr_i[AW+1:2];
    assign load_idx       = load_addr_i[AW+1:2];
    assign fetch_in_range = ({1'b0, req_addr_i} < ADDR_LIMIT);
    assign load_in_range  = ({1'b0, load_addr_i} < ADDR_LIMIT);

`ifdef IMEM_ALIGN_CHECK_EN
    assign fetch_misaligned = (req_addr_i[1:0] != 2'b00);
    assign load_misaligned  = (load_addr_i[1:0] != 2'b00);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr_i[1:0], load_addr_i[1:0]};
    assign fetch_misaligned = 1'b0;
    assign load_misaligned  = 1'b0;
`endif

    assign fetch_err = !fetch_in_range || fetch_misaligned;
    assign load_ok   = load_in_range && !load_misaligned;

    // A load on the same cycle takes priority over a fetch request. That
    // keeps the array single-ported: a cycle has either a read or a write.
    assign req_ready_o = (state == IDLE) && !load_en_i;
    assign accept      = req_valid_i && req_ready_o;

    // The program array has no reset, so that a reset keeps the loaded image.
    // A load strobe is honoured in every state, including during rst.
    always_ff @(posedge clk) begin
        if (load_en_i && load_ok) begin
            mem[load_idx] <= load_data_i;
        end
    end

    // State register and response capture. The word is sampled at the
    // acceptance edge, so later loads cannot change a pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            inst_q <= 32'd0;
            err_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt    <= WAIT_INIT;
                inst_q <= fetch_err ? NOP_INST : mem[fetch_idx];
                err_q  <= fetch_err;
            end else if ((state == WAIT) && (cnt != 3'd0)) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    // Next-state logic. Only one request can be outstanding, so RESP always
    // passes through IDLE before the next request is accepted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rsp_valid_o = (state == RESP);
    assign rsp_inst_o  = rsp_valid_o ? inst_q : 32'd0;
    assign rsp_err_o   = rsp_valid_o ? err_q : 1'b0;
    assign busy_o      = (state != IDLE);

endmodule
